// File: rtl/dyser_pkg.sv
// Shared DySER definitions: default widths, port select type and FIFO space helpers.
// Used by the send queue and by the fabric/switch RTL.
package dyser_pkg;

  localparam int DYSER_DATA_WIDTH = 64;
  localparam int DYSER_NUM_PORTS  = 8;

  typedef logic [$clog2(DYSER_NUM_PORTS)-1:0] port_sel_t;

  // Number of entries the two send lanes want to place into one port this cycle (0..2).
  function automatic int unsigned lane_need(input logic en0, input logic hit0,
                                            input logic en1, input logic hit1);
    int unsigned n;
    n = 0;
    if (en0 && hit0) n = n + 1;
    if (en1 && hit1) n = n + 1;
    return n;
  endfunction

  // A FIFO holding 'count' of 'depth' entries cannot absorb 'need' more.
  function automatic logic lacks_space(input int unsigned need, input int unsigned count,
                                       input int unsigned depth);
    return need > (depth - count);
  endfunction

endpackage

// File: rtl/dyser_port_fifo.sv
// Single fabric-port FIFO: up to two writes and one read per cycle, synchronous flush,
// registered head so the fabric sees data one cycle after it is written.
module dyser_port_fifo #(
  parameter  int DATA_WIDTH = 64,
  parameter  int DEPTH      = 4,
  localparam int CNT_W      = $clog2(DEPTH + 1),
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            wr_cnt,
  input  logic [DATA_WIDTH-1:0] wr_data0,
  input  logic [DATA_WIDTH-1:0] wr_data1,
  input  logic                  rd,
  input  logic                  flush,
  output logic [CNT_W-1:0]      count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_p1;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic                  pop;

  // DEPTH need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    pop       = rd && (count_q != '0);
    wr_ptr_p1 = ptr_inc(wr_ptr_q);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    head_d    = head_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_cnt == 2'd1) wr_ptr_d = wr_ptr_p1;
      if (wr_cnt == 2'd2) wr_ptr_d = ptr_inc(wr_ptr_p1);
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(wr_cnt) - CNT_W'(pop);
      // Surviving entries take priority; an emptied FIFO takes the first new write, else holds.
      if ((count_q - CNT_W'(pop)) != '0) head_d = mem_q[rd_ptr_d];
      else if (wr_cnt != 2'd0)            head_d = wr_data0;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && wr_cnt != 2'd0) mem_q[wr_ptr_q]  <= wr_data0;
    if (!flush && wr_cnt == 2'd2) mem_q[wr_ptr_p1] <= wr_data1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign count = count_q;
  assign head  = head_q;

endmodule

// File: rtl/dyser_send_queue.sv
// Dual-lane core-to-fabric send buffering: decodes both lanes onto per-port FIFOs and
// stalls the core (all-or-nothing) whenever any addressed FIFO lacks room.
module dyser_send_queue
  import dyser_pkg::*;
#(
  parameter  int DATA_WIDTH = DYSER_DATA_WIDTH,
  parameter  int NUM_PORTS  = DYSER_NUM_PORTS,
  parameter  int DEPTH      = 4,
  localparam int PORT_W     = $clog2(NUM_PORTS),
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            send_en0,
  input  logic [PORT_W-1:0]               send_port_r0,
  input  logic [DATA_WIDTH-1:0]           send_data_r0,
  input  logic                            send_en1,
  input  logic [PORT_W-1:0]               send_port_r1,
  input  logic [DATA_WIDTH-1:0]           send_data_r1,
  input  logic                            flush,
  output logic                            send_stall,
  output logic [NUM_PORTS-1:0]            fab_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] fab_data,
  input  logic [NUM_PORTS-1:0]            fab_ready,
  output logic [NUM_PORTS-1:0]            port_full
);

  logic [1:0]            need      [NUM_PORTS];
  logic [1:0]            wr_cnt    [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wd0       [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wd1       [NUM_PORTS];
  logic [CNT_W-1:0]      cnt       [NUM_PORTS];
  logic [NUM_PORTS-1:0]  short_space;
  logic [NUM_PORTS-1:0]  hit0, hit1;

  // Space is judged on the pre-pop count, so a pop never lends credit to a same-cycle send.
  always_comb begin
    short_space = '0;
    hit0        = '0;
    hit1        = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      hit0[p]        = send_en0 && (send_port_r0 == PORT_W'(p));
      hit1[p]        = send_en1 && (send_port_r1 == PORT_W'(p));
      need[p]        = 2'(lane_need(send_en0, hit0[p], send_en1, hit1[p]));
      short_space[p] = lacks_space(32'(need[p]), 32'(cnt[p]), DEPTH);
      wd0[p]         = hit0[p] ? send_data_r0 : send_data_r1;
      wd1[p]         = send_data_r1;
    end
    send_stall = !flush && (|short_space);
    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_cnt[p] = send_stall ? 2'd0 : need[p];
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    dyser_port_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_cnt   (wr_cnt[p]),
      .wr_data0 (wd0[p]),
      .wr_data1 (wd1[p]),
      .rd       (fab_ready[p]),
      .flush    (flush),
      .count    (cnt[p]),
      .head     (fab_data[p*DATA_WIDTH +: DATA_WIDTH])
    );
    assign fab_valid[p] = (cnt[p] != '0);
    assign port_full[p] = (cnt[p] == CNT_W'(DEPTH));
  end

endmodule

// File: tb/tb_dyser_send_queue.sv
// Self-checking bench for dyser_send_queue: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_dyser_send_queue;

  localparam int DW    = 64;
  localparam int NP    = 8;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          send_en0, send_en1, flush;
  logic [2:0]    send_port_r0, send_port_r1;
  logic [DW-1:0] send_data_r0, send_data_r1;
  logic          send_stall;
  logic [NP-1:0] fab_valid, fab_ready, port_full;
  logic [NP*DW-1:0] fab_data;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mq [NP][$];

  typedef struct {
    logic          en0;
    logic [2:0]    p0;
    logic [DW-1:0] d0;
    logic          en1;
    logic [2:0]    p1;
    logic [DW-1:0] d1;
    logic          fl;
    logic [NP-1:0] rdy;
    logic          xs;
    logic [NP-1:0] xv;
    logic [NP-1:0] xf;
    logic          chk;
    logic [2:0]    cp;
    logic [DW-1:0] cd;
  } vec_t;

  vec_t tbl [11];

  dyser_send_queue #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .send_en0     (send_en0),
    .send_port_r0 (send_port_r0),
    .send_data_r0 (send_data_r0),
    .send_en1     (send_en1),
    .send_port_r1 (send_port_r1),
    .send_data_r1 (send_data_r1),
    .flush        (flush),
    .send_stall   (send_stall),
    .fab_valid    (fab_valid),
    .fab_data     (fab_data),
    .fab_ready    (fab_ready),
    .port_full    (port_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic modelStall();
    int need;
    if (flush) return 1'b0;
    for (int p = 0; p < NP; p++) begin
      need = 0;
      if (send_en0 && int'(send_port_r0) == p) need++;
      if (send_en1 && int'(send_port_r1) == p) need++;
      if (need > DEPTH - mq[p].size()) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic modelEdge(input logic s);
    if (flush) begin
      for (int p = 0; p < NP; p++) mq[p].delete();
    end else begin
      for (int p = 0; p < NP; p++)
        if (fab_ready[p] && mq[p].size() > 0) void'(mq[p].pop_front());
      if (!s) begin
        if (send_en0) mq[send_port_r0].push_back(send_data_r0);
        if (send_en1) mq[send_port_r1].push_back(send_data_r1);
      end
    end
  endtask

  task automatic checkOutput();
    logic [NP-1:0] ev, ef;
    for (int p = 0; p < NP; p++) begin
      ev[p] = (mq[p].size() > 0);
      ef[p] = (mq[p].size() == DEPTH);
    end
    cmp("model_valid", DW'(fab_valid), DW'(ev));
    cmp("model_full", DW'(port_full), DW'(ef));
    for (int p = 0; p < NP; p++)
      if (mq[p].size() > 0) cmp($sformatf("model_data%0d", p), fab_data[p*DW +: DW], mq[p][0]);
  endtask

  task automatic drive(input logic e0, input logic [2:0] p0, input logic [DW-1:0] d0,
                       input logic e1, input logic [2:0] p1, input logic [DW-1:0] d1,
                       input logic fl, input logic [NP-1:0] rdy);
    send_en0 = e0; send_port_r0 = p0; send_data_r0 = d0;
    send_en1 = e1; send_port_r1 = p1; send_data_r1 = d1;
    flush = fl; fab_ready = rdy;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.en0, v.p0, v.d0, v.en1, v.p1, v.d1, v.fl, v.rdy);
  endtask

  // Called just after a rising edge; checks stall mid-cycle and outputs just after the next edge.
  task automatic stepCycle(output logic stall_seen);
    logic s;
    @(negedge clk);
    s = modelStall();
    stall_seen = send_stall;
    cmp("model_stall", DW'(send_stall), DW'(s));
    @(posedge clk);
    modelEdge(s);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n, input logic [NP-1:0] rdy);
    logic st;
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 3'd0, '0, 1'b0, 3'd0, '0, 1'b0, rdy);
      stepCycle(st);
    end
  endtask

  initial begin
    logic st;
    tbl[0]  = '{1'b1, 3'd4, 64'h0,  1'b1, 3'd3, 64'h1,  1'b0, 8'h00, 1'b0, 8'h18, 8'h00, 1'b1, 3'd4, 64'h0};
    tbl[1]  = '{1'b0, 3'd0, 64'h0,  1'b0, 3'd0, 64'h0,  1'b0, 8'h00, 1'b0, 8'h18, 8'h00, 1'b1, 3'd3, 64'h1};
    tbl[2]  = '{1'b1, 3'd7, 64'h9,  1'b0, 3'd0, 64'h0,  1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 64'h0};
    tbl[3]  = '{1'b1, 3'd2, 64'h55, 1'b1, 3'd2, 64'hff, 1'b0, 8'h00, 1'b0, 8'h04, 8'h00, 1'b1, 3'd2, 64'h55};
    tbl[4]  = '{1'b1, 3'd2, 64'h55, 1'b1, 3'd2, 64'hff, 1'b0, 8'h00, 1'b0, 8'h04, 8'h04, 1'b1, 3'd2, 64'h55};
    tbl[5]  = '{1'b1, 3'd2, 64'h1,  1'b0, 3'd0, 64'h0,  1'b0, 8'h04, 1'b1, 8'h04, 8'h00, 1'b1, 3'd2, 64'hff};
    tbl[6]  = '{1'b1, 3'd2, 64'h1,  1'b0, 3'd0, 64'h0,  1'b0, 8'h00, 1'b0, 8'h04, 8'h04, 1'b1, 3'd2, 64'hff};
    tbl[7]  = '{1'b0, 3'd0, 64'h0,  1'b0, 3'd0, 64'h0,  1'b0, 8'h04, 1'b0, 8'h04, 8'h00, 1'b1, 3'd2, 64'h55};
    tbl[8]  = '{1'b0, 3'd0, 64'h0,  1'b0, 3'd0, 64'h0,  1'b0, 8'h04, 1'b0, 8'h04, 8'h00, 1'b1, 3'd2, 64'hff};
    tbl[9]  = '{1'b0, 3'd0, 64'h0,  1'b0, 3'd0, 64'h0,  1'b0, 8'h04, 1'b0, 8'h04, 8'h00, 1'b1, 3'd2, 64'h1};
    tbl[10] = '{1'b0, 3'd0, 64'h0,  1'b0, 3'd0, 64'h0,  1'b0, 8'h04, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 64'h0};

    rst_n = 1'b0;
    drive(1'b0, 3'd0, '0, 1'b0, 3'd0, '0, 1'b0, '0);
    #3;
    cmp("reset_valid", DW'(fab_valid), '0);
    cmp("reset_full", DW'(port_full), '0);
    cmp("reset_stall", DW'(send_stall), '0);
    cmp("reset_data", fab_data[4*DW +: DW], '0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed table");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i]);
      stepCycle(st);
      cmp($sformatf("tbl%0d_stall", i), DW'(st), DW'(tbl[i].xs));
      cmp($sformatf("tbl%0d_valid", i), DW'(fab_valid), DW'(tbl[i].xv));
      cmp($sformatf("tbl%0d_full", i), DW'(port_full), DW'(tbl[i].xf));
      if (tbl[i].chk) cmp($sformatf("tbl%0d_data", i), fab_data[tbl[i].cp*DW +: DW], tbl[i].cd);
    end

    $display("[TB] stall on port 6");
    drive(1'b1, 3'd6, 64'ha, 1'b1, 3'd6, 64'hb, 1'b0, '0); stepCycle(st);
    drive(1'b1, 3'd6, 64'hc, 1'b0, 3'd0, '0, 1'b0, '0);    stepCycle(st);
    drive(1'b1, 3'd6, 64'hd, 1'b1, 3'd6, 64'he, 1'b0, '0); stepCycle(st);
    cmp("p6_stall_full3", DW'(st), 64'h1);
    drive(1'b1, 3'd6, 64'hd, 1'b1, 3'd6, 64'he, 1'b0, 8'h40); stepCycle(st);
    cmp("p6_stall_no_pop_credit", DW'(st), 64'h1);
    drive(1'b1, 3'd6, 64'hd, 1'b1, 3'd6, 64'he, 1'b0, '0); stepCycle(st);
    cmp("p6_accept", DW'(st), 64'h0);
    cmp("p6_full_after", DW'(port_full[6]), 64'h1);
    idle(5, 8'hff);

    $display("[TB] full push and pop on port 0");
    drive(1'b1, 3'd0, 64'h1, 1'b1, 3'd0, 64'h2, 1'b0, '0); stepCycle(st);
    drive(1'b1, 3'd0, 64'h3, 1'b1, 3'd0, 64'h4, 1'b0, '0); stepCycle(st);
    drive(1'b1, 3'd0, 64'h5, 1'b0, 3'd0, '0, 1'b0, 8'h01); stepCycle(st);
    cmp("p0_full_stall", DW'(st), 64'h1);
    drive(1'b1, 3'd0, 64'h5, 1'b0, 3'd0, '0, 1'b0, 8'h01); stepCycle(st);
    cmp("p0_push_pop_accept", DW'(st), 64'h0);
    cmp("p0_head", fab_data[0 +: DW], 64'h3);
    idle(5, 8'hff);

    $display("[TB] flush");
    drive(1'b1, 3'd1, 64'h77, 1'b0, 3'd0, '0, 1'b0, '0); stepCycle(st);
    drive(1'b1, 3'd7, 64'h88, 1'b0, 3'd0, '0, 1'b1, '0); stepCycle(st);
    cmp("flush_valid", DW'(fab_valid), '0);

    $display("[TB] reset mid-fill");
    drive(1'b1, 3'd3, 64'h31, 1'b1, 3'd3, 64'h32, 1'b0, '0); stepCycle(st);
    cmp("prefill_valid3", DW'(fab_valid[3]), 64'h1);
    drive(1'b1, 3'd3, 64'h33, 1'b0, 3'd0, '0, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    cmp("async_reset_valid", DW'(fab_valid), '0);
    cmp("async_reset_full", DW'(port_full), '0);
    cmp("async_reset_stall", DW'(send_stall), '0);
    cmp("async_reset_data3", fab_data[3*DW +: DW], '0);
    for (int p = 0; p < NP; p++) mq[p].delete();
    drive(1'b0, 3'd0, '0, 1'b0, 3'd0, '0, 1'b0, '0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic [NP-1:0] r;
      for (int p = 0; p < NP; p++) r[p] = ($urandom_range(0, 2) == 0);
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), {$urandom, $urandom},
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), {$urandom, $urandom},
            ($urandom_range(0, 31) == 0), r);
      stepCycle(st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
